// File: rtl/mux_2x1_rr_arbiter_if.sv
// mux_2x1_rr_arbiter_if: two requester paths plus the shared valid/ready output of the arbitrated 2:1 mux
interface mux_2x1_rr_arbiter_if #(parameter int WIDTH = 8);
  logic req0, req1, last0, last1, out_ready;
  logic [WIDTH-1:0] d0, d1, out_data;
  logic gnt0, gnt1, sel, out_valid, out_last;
  modport slave (
    input  req0, req1, last0, last1, d0, d1, out_ready,
    output gnt0, gnt1, sel, out_valid, out_data, out_last
  );
  modport master (
    output req0, req1, last0, last1, d0, d1, out_ready,
    input  gnt0, gnt1, sel, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mux_2x1_rr_arbiter.sv
// mux_2x1_rr_arbiter: round-robin owner of a shared 2:1 mux with valid/ready output; ARB_BURST_LIMIT_EN adds MAX_BURST pre-emption
module mux_2x1_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  mux_2x1_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state;
  logic sel, prio, own, req_n, req_o, last_n, acc, done, pick, preempt, valid;
  logic [WIDTH-1:0] data;
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be >= 1");
  end
  assign own    = state == OWN1;
  assign req_n  = own ? bus.req1 : bus.req0;
  assign req_o  = own ? bus.req0 : bus.req1;
  assign last_n = own ? bus.last1 : bus.last0;
  assign valid  = state != IDLE && req_n;
  assign acc    = valid && bus.out_ready;
  assign done   = acc && last_n;
  assign pick   = bus.req0 && bus.req1 ? prio : bus.req1;
`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt;
  // the MAX_BURST-th beat hands over on its own edge so the owner never gets an extra beat
  assign preempt = valid && req_o && (cnt == CW'(MAX_BURST) || acc && cnt == CW'(MAX_BURST - 1));
  always_ff @(posedge clk)
    if (rst || !valid || done && req_o || preempt) cnt <= '0;
    else if (acc && cnt != CW'(MAX_BURST)) cnt <= cnt + 1'b1;
`else
  assign preempt = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      prio  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req0 || bus.req1) begin
        state <= pick ? OWN1 : OWN0;
        sel   <= pick;
      end
    end else if (!req_n || done || preempt) begin
      prio <= ~own;
      if (!req_n) state <= IDLE;
      else if (req_o) begin
        state <= own ? OWN0 : OWN1;
        sel   <= ~own;
      end
    end
  assign data          = sel ? bus.d1 : bus.d0;
  assign bus.gnt0      = state == OWN0;
  assign bus.gnt1      = state == OWN1;
  assign bus.sel       = sel;
  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.out_last  = valid && (sel ? bus.last1 : bus.last0);
endmodule

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 mux datapath between two requesters.
- Each requester presents data, a request and an end-of-transfer marker.
- The arbiter grants one requester per transfer, drives the mux select and forwards a valid/ready handshake to a single downstream consumer.
- Sits in front of any shared sink fed through a Mux_2x1-style select, replacing hand-driven S with sequenced control.

Parameters:
- WIDTH, 8, data width of each requester path and of out_data.
- MAX_BURST, 4, beats per grant before forced rotation; used only with ARB_BURST_LIMIT_EN; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 requests or holds its transfer.
- req1  input  1  requester 1 requests or holds its transfer.
- last0  input  1  current beat from requester 0 is the final beat of its transfer.
- last1  input  1  current beat from requester 1 is the final beat of its transfer.
- d0  input  WIDTH  requester 0 data (mux input I0).
- d1  input  WIDTH  requester 1 data (mux input I1).
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt0  output  1  requester 0 owns the datapath; its beat is accepted when gnt0 & req0 & out_ready.
- gnt1  output  1  requester 1 owns the datapath; same acceptance rule with req1.
- sel  output  1  registered mux select: 0 = d0, 1 = d1.
- out_valid  output  1  gnt0&req0 | gnt1&req1 (combinational from registered grant).
- out_data  output  WIDTH  sel ? d1 : d0 (combinational).
- out_last  output  1  sel ? last1 : last0, qualified by out_valid.

Behaviour:
- States: IDLE, OWN0, OWN1.
  - gnt0 = (state==OWN0); gnt1 = (state==OWN1).
  - sel is a register, updated together with state; it holds its value in IDLE.
- Priority register prio (1 bit) = requester favoured on the next arbitration. After a transfer by requester n completes, prio = ~n.
- Reset (rst=1 at a clock edge, at any time including mid-transfer):
  - state=IDLE, gnt0=gnt1=0, sel=0, prio=0, burst counter=0.
  - out_valid=0 the cycle after; any in-flight transfer is dropped with no completion.
- IDLE:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - both -> OWN[prio].
  - none -> stay.
  - Grant latency: 1 cycle from req seen high to gnt high.
- OWNn, per cycle:
  - Beat accepted (reqn & out_ready) with lastn=1: transfer complete.
    - Other requester requesting -> OWN[other] next cycle (zero-bubble handover).
    - Else reqn still high -> OWNn (new transfer, same owner).
    - Else -> IDLE.
    - prio updated to ~n in all three cases.
  - Beat accepted with lastn=0: stay OWNn.
  - reqn low: abort -> IDLE next cycle, prio=~n, no beat accepted.
  - out_ready low with reqn high: hold state; requester must keep d/last stable (not checked).
- Grant never changes mid-transfer; a non-owner's request is ignored until the owner's last beat or abort.
- Both requesters hold req until their last beat is accepted.

Optional Feature:
- Macro ARB_BURST_LIMIT_EN.
- Defined:
  - A counter (width clog2(MAX_BURST+1)) counts accepted beats in OWNn; cleared on every grant change and in IDLE.
  - When the count reaches MAX_BURST and the other requester is requesting, the grant is pre-empted: next state OWN[other], prio=~n.
  - The pre-empted requester keeps req high and resumes the remainder when re-granted. Its last marker is not required at the pre-emption point.
- Undefined: no counter logic; transfers of any length run to lastn or abort.

Test Plan:
- Reset, req0=1, d0=8'hA5, last0=1, out_ready=1 -> gnt0=1 on cycle 1 after req; out_valid=1, out_data=8'hA5, sel=0; then IDLE, prio=1.
- req0=req1=1 from IDLE after reset, both single-beat transfers repeated -> grants alternate OWN0, OWN1, OWN0, OWN1 with no idle cycle between them.
- OWN1 with 3-beat transfer (last1 on beat 3), out_ready toggling 1,0,1,0,1; req0 high throughout -> gnt1 held 5 cycles, 3 beats accepted, gnt0 on the following cycle.
- OWN0 mid-transfer, rst=1 for one cycle -> next cycle gnt0=gnt1=0, out_valid=0, sel=0; with req1=1 only, gnt1=1 one cycle after rst drops.
- OWN0, req0 dropped before last0 -> IDLE next cycle, no beat counted; pending req1 granted the following cycle.
- With ARB_BURST_LIMIT_EN, MAX_BURST=4, req0 sends a 6-beat transfer, req1 pending -> gnt0 for 4 accepted beats, then gnt1; after req1's last beat, gnt0 returns and finishes beats 5–6.
